tapper_score_keeper: RTL and testbench

- Game score engine for the Tapper clone: synchronizes raw hit/miss/start event inputs and maintains a signed 8-bit two's-complement score.
- Runs a small game-state FSM.
- Directly upstream of the signed three-digit 7-segment display stage: `score` drives that stage's 8-bit `val` input unchanged.

---
 rtl/tapper_score_keeper.sv | 116 +++++++++++
 tb/tb_tapper_score_keeper.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/tapper_score_keeper.sv
// Tapper score engine: synchronizes raw start/hit/miss, runs the game FSM and keeps a
// clamped signed 8-bit score plus a saturating hit counter.
module tapper_score_keeper #(
  parameter int unsigned HIT_POINTS   = 5,
  parameter int unsigned MISS_PENALTY = 10,
  parameter int signed   WIN_SCORE    = 100,
  parameter int signed   LOSE_SCORE   = -50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_in,
  input  logic              hit_in,
  input  logic              miss_in,
  output logic signed [7:0] score,
  output logic [1:0]        state,
  output logic              game_over,
  output logic              game_won,
  output logic [7:0]        hit_count
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StWon  = 2'd2,
    StLost = 2'd3
  } state_e;

  localparam logic signed [9:0] HitDelta  = 10'(HIT_POINTS);
  localparam logic signed [9:0] MissDelta = 10'(MISS_PENALTY);
  localparam logic signed [9:0] WinLim    = 10'(WIN_SCORE);
  localparam logic signed [9:0] LoseLim   = 10'(LOSE_SCORE);

  // Bit order for all conditioning vectors: {start, hit, miss}
  logic [2:0] r_sync1, r_sync2, r_hist;
  logic [2:0] w_pulse;
  logic       w_start, w_hit, w_miss;

  state_e            r_state;
  logic signed [7:0] r_score;
  logic [7:0]        r_hit_count;

  logic signed [9:0] w_add, w_sub, w_sum, w_next_ext;
  logic signed [7:0] w_next;
  logic [7:0]        w_hc_inc;
  logic              w_win, w_lose;

  assign w_pulse = r_sync2 & ~r_hist;
  assign w_start = w_pulse[2];
  assign w_hit   = w_pulse[1];
  assign w_miss  = w_pulse[0];

  always_comb begin
    w_add = w_hit  ? HitDelta  : 10'sd0;
    w_sub = w_miss ? MissDelta : 10'sd0;
    w_sum = {{2{r_score[7]}}, r_score} + w_add - w_sub;
    // Clamp to the 8-bit range so the score never wraps
    if (w_sum > 10'sd127) begin
      w_next = 8'sd127;
    end else if (w_sum < -10'sd128) begin
      w_next = -8'sd128;
    end else begin
      w_next = w_sum[7:0];
    end
    w_next_ext = {{2{w_next[7]}}, w_next};
    w_win      = (w_next_ext >= WinLim);
    w_lose     = (w_next_ext <= LoseLim);
    w_hc_inc   = (r_hit_count == 8'hFF) ? r_hit_count : r_hit_count + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_hist      <= '0;
      r_state     <= StIdle;
      r_score     <= '0;
      r_hit_count <= '0;
    end else begin
      r_sync1 <= {start_in, hit_in, miss_in};
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      unique case (r_state)
        StIdle, StWon, StLost: begin
          if (w_start) begin
            r_state     <= StPlay;
            r_score     <= '0;
            r_hit_count <= '0;
          end
        end
        StPlay: begin
          // A restart wins over any hit/miss pulse in the same cycle
          if (w_start) begin
            r_score     <= '0;
            r_hit_count <= '0;
          end else if (w_hit || w_miss) begin
            r_score <= w_next;
            if (w_hit) r_hit_count <= w_hc_inc;
            if (w_win) begin
              r_state <= StWon;
            end else if (w_lose) begin
              r_state <= StLost;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign score     = r_score;
  assign state     = r_state;
  assign hit_count = r_hit_count;
  assign game_over = (r_state == StWon) || (r_state == StLost);
  assign game_won  = (r_state == StWon);

endmodule

// File: tb/tb_tapper_score_keeper.sv
// Bench for tapper_score_keeper: a default instance plus one with HIT_POINTS=100,
// WIN_SCORE=127; table of event records checked through an expectation queue.
module tb_tapper_score_keeper;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_a = 1'b0, hit_a = 1'b0, miss_a = 1'b0;
  logic start_b = 1'b0, hit_b = 1'b0, miss_b = 1'b0;

  logic signed [7:0] score_a, score_b;
  logic [1:0]        state_a, state_b;
  logic              over_a, over_b, won_a, won_b;
  logic [7:0]        hc_a, hc_b;

  always #5 clk = ~clk;

  tapper_score_keeper u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .start_in  (start_a),
    .hit_in    (hit_a),
    .miss_in   (miss_a),
    .score     (score_a),
    .state     (state_a),
    .game_over (over_a),
    .game_won  (won_a),
    .hit_count (hc_a)
  );

  tapper_score_keeper #(
    .HIT_POINTS (100),
    .WIN_SCORE  (127)
  ) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .start_in  (start_b),
    .hit_in    (hit_b),
    .miss_in   (miss_b),
    .score     (score_b),
    .state     (state_b),
    .game_over (over_b),
    .game_won  (won_b),
    .hit_count (hc_b)
  );

  typedef struct {
    bit    alt;
    bit    s, h, m;
    int    sc;
    int    st;
    int    hc;
    string nm;
  } vec_t;

  vec_t vecs[37];
  vec_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic set_in(input bit alt, input bit s, input bit h, input bit m);
    if (alt) begin
      start_b = s; hit_b = h; miss_b = m;
    end else begin
      start_a = s; hit_a = h; miss_a = m;
    end
  endtask

  // Pop the oldest expectation and compare it against the selected instance
  task automatic check_pop();
    vec_t e;
    if (exp_q.size() == 0) begin
      chk("queue_underflow", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    if (e.alt) begin
      chk({e.nm, ".score"}, int'(score_b), e.sc);
      chk({e.nm, ".state"}, int'(state_b), e.st);
      chk({e.nm, ".hit_count"}, int'(hc_b), e.hc);
      chk({e.nm, ".game_over"}, int'(over_b), int'(e.st >= 2));
      chk({e.nm, ".game_won"}, int'(won_b), int'(e.st == 2));
    end else begin
      chk({e.nm, ".score"}, int'(score_a), e.sc);
      chk({e.nm, ".state"}, int'(state_a), e.st);
      chk({e.nm, ".hit_count"}, int'(hc_a), e.hc);
      chk({e.nm, ".game_over"}, int'(over_a), int'(e.st >= 2));
      chk({e.nm, ".game_won"}, int'(won_a), int'(e.st == 2));
    end
  endtask

  // Raise the requested raw inputs at a falling edge, hold, then compare and release
  task automatic run_vec(input vec_t v, input int hold);
    exp_q.push_back(v);
    set_in(v.alt, v.s, v.h, v.m);
    repeat (hold) @(negedge clk);
    check_pop();
    set_in(v.alt, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  function automatic vec_t mk(input bit alt, input bit s, input bit h, input bit m,
                              input int sc, input int st, input int hc, input string nm);
    vec_t v;
    v.alt = alt; v.s = s; v.h = h; v.m = m;
    v.sc = sc; v.st = st; v.hc = hc; v.nm = nm;
    return v;
  endfunction

  initial begin
    vec_t hold_v;

    vecs[0]  = mk(0, 0, 1, 0,   0, 0, 0, "idle_hit_ignored");
    vecs[1]  = mk(0, 1, 0, 0,   0, 1, 0, "start");
    vecs[2]  = mk(0, 0, 1, 0,   5, 1, 1, "hit1");
    vecs[3]  = mk(0, 0, 1, 0,  10, 1, 2, "hit2");
    vecs[4]  = mk(0, 0, 1, 0,  15, 1, 3, "hit3");
    vecs[5]  = mk(0, 1, 0, 0,   0, 1, 0, "restart");
    vecs[6]  = mk(0, 0, 0, 1, -10, 1, 0, "miss1");
    vecs[7]  = mk(0, 0, 0, 1, -20, 1, 0, "miss2");
    vecs[8]  = mk(0, 0, 0, 1, -30, 1, 0, "miss3");
    vecs[9]  = mk(0, 0, 0, 1, -40, 1, 0, "miss4");
    vecs[10] = mk(0, 0, 0, 1, -50, 3, 0, "miss5_lost");
    vecs[11] = mk(0, 0, 0, 1, -50, 3, 0, "lost_frozen");
    vecs[12] = mk(0, 1, 0, 0,   0, 1, 0, "start_from_lost");
    vecs[13] = mk(0, 0, 1, 0,   5, 1, 1, "hitA");
    vecs[14] = mk(0, 0, 1, 0,  10, 1, 2, "hitB");
    vecs[15] = mk(0, 0, 1, 0,  15, 1, 3, "hitC");
    vecs[16] = mk(0, 0, 1, 0,  20, 1, 4, "hitD");
    vecs[17] = mk(0, 0, 1, 1,  15, 1, 5, "hit_and_miss");
    vecs[18] = mk(0, 0, 1, 0,  25, 1, 7, "hitE");
    vecs[19] = mk(0, 0, 1, 0,  30, 1, 8, "hitF");
    vecs[20] = mk(0, 0, 1, 0,  35, 1, 9, "hitG");
    vecs[21] = mk(0, 0, 1, 0,  40, 1, 10, "hitH");
    vecs[22] = mk(0, 1, 1, 0,   0, 1, 0, "start_plus_hit");
    for (int i = 0; i < 7; i++) vecs[23 + i] = mk(0, 0, 1, 0, 5 * (i + 1), 1, i + 1, "climb");
    vecs[30] = mk(0, 0, 1, 0,   0, 0, 0, "post_reset_hit");
    vecs[31] = mk(0, 0, 0, 1,   0, 0, 0, "post_reset_miss");
    vecs[32] = mk(1, 1, 0, 0,   0, 1, 0, "b_start");
    vecs[33] = mk(1, 0, 1, 1,  90, 1, 1, "b_net90");
    vecs[34] = mk(1, 0, 1, 0, 127, 2, 2, "b_clamp_won");
    vecs[35] = mk(1, 0, 1, 0, 127, 2, 2, "b_won_frozen");
    vecs[36] = mk(1, 1, 0, 0,   0, 1, 0, "b_restart");

    repeat (2) @(negedge clk);
    chk("reset.score", int'(score_a), 0);
    chk("reset.state", int'(state_a), 0);
    chk("reset.game_over", int'(over_a), 0);
    chk("reset.game_won", int'(won_a), 0);
    chk("reset.hit_count", int'(hc_a), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i <= 17; i++) run_vec(vecs[i], 3);

    // Held-high hit must produce exactly one +5
    hold_v = mk(0, 0, 1, 0, 20, 1, 6, "hold_hit_100");
    run_vec(hold_v, 100);
    hold_v = mk(0, 0, 0, 0, 20, 1, 6, "hold_hit_release");
    run_vec(hold_v, 3);

    for (int i = 18; i <= 29; i++) run_vec(vecs[i], 3);

    // Asynchronous reset between edges at score 35
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst.score", int'(score_a), 0);
    chk("async_rst.state", int'(state_a), 0);
    chk("async_rst.hit_count", int'(hc_a), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 30; i <= 36; i++) run_vec(vecs[i], 3);

    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got %0d checks, expected completion",
             n_total);
    $fatal(1);
  end

endmodule
